// File: rtl/i2c_pkg.sv
// Shared state encoding and framing constants for the I2C write master.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_STOP,
    ST_DONE
  } state_e;

  typedef logic [1:0] qtr_t;

  localparam qtr_t Q0 = 2'd0;
  localparam qtr_t Q1 = 2'd1;
  localparam qtr_t Q2 = 2'd2;
  localparam qtr_t Q3 = 2'd3;

  localparam int START_QTRS    = 2;
  localparam int STOP_QTRS     = 3;
  localparam int BITS_PER_BYTE = 9;

endpackage

// File: rtl/i2c_tick_gen.sv
// SCL quarter-period divider: one-cycle tick every QTR_CYCLES clocks,
// cleared by restart, frozen by hold.
module i2c_tick_gen #(
  parameter int QTR_CYCLES = 125
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic hold,
  output logic tick
);

  localparam int CNT_W = $clog2(QTR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QTR_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = ~restart & ~hold & (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              cnt <= '0;
    else if (restart)          cnt <= '0;
    else if (hold)             cnt <= cnt;
    else if (cnt == CNT_LAST)  cnt <= '0;
    else                       cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/i2c_write_engine.sv
// I2C write master: START, address+W, 0..MAX_BYTES payload bytes with ACK
// checking, STOP. Optional clock stretching via `define I2C_CLK_STRETCH_EN.
module i2c_write_engine
  import i2c_pkg::*;
#(
  parameter int QTR_CYCLES = 125,
  parameter int MAX_BYTES  = 4,
  parameter int LEN_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [6:0]             dev_address,
  input  logic [8*MAX_BYTES-1:0] wr_data,
  input  logic [LEN_W-1:0]       wr_len,
  input  logic                   sda_in,
  input  logic                   scl_in,
  output logic                   sda_oe,
  output logic                   scl_oe,
  output logic                   busy,
  output logic                   done,
  output logic                   nack,
  output logic [LEN_W-1:0]       nack_index
);

  localparam int         SR_W       = 8 * (MAX_BYTES + 1);
  localparam logic [3:0] LAST_BIT   = 4'(BITS_PER_BYTE - 1);
  localparam qtr_t       START_LAST = qtr_t'(START_QTRS - 1);
  localparam qtr_t       STOP_LAST  = qtr_t'(STOP_QTRS - 1);

  state_e           state, state_nx;
  qtr_t             qtr;
  logic [3:0]       bit_cnt;
  logic [LEN_W-1:0] byte_idx, len_q, len_clip;
  logic [SR_W-1:0]  sr;
  logic             ack_q;
  logic             tick, hold, restart, scl_free;

  assign len_clip = (wr_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : wr_len;
  assign restart  = (state == ST_IDLE) || (state == ST_DONE);
  assign busy     = ~restart;
  assign done     = (state == ST_DONE);

  // Phases where the master has SCL released and a slave may stretch it
  assign scl_free = ((state == ST_BIT) && qtr[1]) || ((state == ST_STOP) && (qtr == Q1));

`ifdef I2C_CLK_STRETCH_EN
  assign hold = scl_free & ~scl_in;
`else
  logic unused_stretch;
  assign hold           = 1'b0;
  assign unused_stretch = scl_in ^ scl_free;
`endif

  i2c_tick_gen #(.QTR_CYCLES(QTR_CYCLES)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .hold    (hold),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sda_oe   = 1'b0;
    scl_oe   = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_START;
      ST_START: begin
        sda_oe = 1'b1;
        scl_oe = (qtr == Q1);
        if (tick && qtr == START_LAST) state_nx = ST_BIT;
      end
      ST_BIT: begin
        scl_oe = ~qtr[1];
        sda_oe = (bit_cnt == LAST_BIT) ? 1'b0 : ~sr[SR_W-1];
        if (tick && qtr == Q3 && bit_cnt == LAST_BIT && (ack_q || byte_idx == len_q))
          state_nx = ST_STOP;
      end
      ST_STOP: begin
        scl_oe = (qtr == Q0);
        sda_oe = (qtr != Q2);
        if (tick && qtr == STOP_LAST) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Bit/byte counters and the address+payload shift register (MSB on the wire first)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qtr        <= Q0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      len_q      <= '0;
      sr         <= '0;
      ack_q      <= 1'b0;
      nack       <= 1'b0;
      nack_index <= '0;
    end else if (state == ST_IDLE) begin
      qtr <= Q0;
      if (start) begin
        sr         <= {dev_address, 1'b0, wr_data};
        len_q      <= len_clip;
        bit_cnt    <= '0;
        byte_idx   <= '0;
        nack       <= 1'b0;
        nack_index <= '0;
      end
    end else if (tick) begin
      qtr <= (state_nx != state) ? Q0 : qtr + 2'd1;
      if (state == ST_BIT) begin
        if (qtr == Q2) ack_q <= sda_in;
        if (qtr == Q3) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt  <= '0;
            byte_idx <= byte_idx + LEN_W'(1);
            if (ack_q) begin
              nack       <= 1'b1;
              nack_index <= byte_idx;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            sr      <= {sr[SR_W-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: bus-level slave model decodes bytes, ACKs or
// NACKs on request and counts STOPs; vector table plus hand sequences.
module tb_i2c_write_engine;
  localparam int QTR = 4;
  localparam int MAXB = 4;
  localparam int LW = 3;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [6:0] dev_address = '0;
  logic [31:0] wr_data = '0;
  logic [LW-1:0] wr_len = '0;
  logic sda_in, scl_in, sda_oe, scl_oe, busy, done, nack;
  logic [LW-1:0] nack_index;
  logic slave_pull = 1'b0, stretch_pull = 1'b0;

  assign sda_in = ~(sda_oe | slave_pull);
  assign scl_in = ~(scl_oe | stretch_pull);

  always #5 clk = ~clk;

  i2c_write_engine #(.QTR_CYCLES(QTR), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dev_address(dev_address),
    .wr_data(wr_data), .wr_len(wr_len), .sda_in(sda_in), .scl_in(scl_in),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .busy(busy), .done(done),
    .nack(nack), .nack_index(nack_index)
  );

  typedef struct {
    logic [6:0]    addr;
    logic [31:0]   data;
    logic [LW-1:0] len;
    int            nack_at;
    int            exp_busy;
    int            exp_nbytes;
    logic          exp_nack;
    logic [LW-1:0] exp_idx;
  } vec_t;

  int total = 0, bad = 0;

  // slave / bus monitor state
  logic psda = 1'b1, pscl = 1'b1, sl, cl;
  logic [7:0] shb = '0;
  logic [7:0] rx [256];
  int bitn = 0, byte_in = 0, rx_n = 0, stops = 0, nack_at = -1;
  int stretch_left = 0;
  bit stretch_arm = 0, stretch_used = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      slave_pull = 1'b0; stretch_pull = 1'b0; bitn = 0; byte_in = 0;
      psda = 1'b1; pscl = 1'b1; stretch_left = 0;
    end else begin
      sl = sda_in; cl = scl_in;
      if (pscl && cl && psda && !sl) begin bitn = 0; byte_in = 0; end
      if (pscl && cl && !psda && sl) stops++;
      if (!pscl && cl) begin
        if (bitn < 8) begin
          shb = {shb[6:0], sl};
          bitn++;
          if (bitn == 8) begin rx[rx_n % 256] = shb; rx_n++; byte_in++; end
        end else bitn = 0;
      end
      if (pscl && !cl) slave_pull = (bitn == 8) && (byte_in - 1 != nack_at);
      if (stretch_left > 0) begin
        stretch_left--;
        if (stretch_left == 0) stretch_pull = 1'b0;
      end else if (stretch_arm && !stretch_used && byte_in == 2 && bitn == 8 && !scl_oe) begin
        stretch_pull = 1'b1; stretch_left = 20; stretch_used = 1;
      end
      pscl = cl; psda = sl;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input vec_t v, input int k);
    if (k == 0) return {v.addr, 1'b0};
    return v.data[8*(5-k)-1 -: 8];
  endfunction

  task automatic wait_done(output int cnt, output bit got);
    cnt = 0; got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      if (done) got = 1;
    end
  endtask

  task automatic check_result(input vec_t v, input string tag, input int base, input int sbase,
                              input int cnt, input bit got);
    check({tag, " done_seen"}, got, 1);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " busy_cycles"}, cnt, v.exp_busy);
    check({tag, " nack"}, nack, v.exp_nack);
    check({tag, " nack_index"}, nack_index, v.exp_idx);
    check({tag, " nbytes"}, rx_n - base, v.exp_nbytes);
    check({tag, " stops"}, stops - sbase, 1);
    for (int k = 0; k < v.exp_nbytes && k < rx_n - base; k++)
      check($sformatf("%s byte%0d", tag, k), rx[(base + k) % 256], exp_byte(v, k));
  endtask

  task automatic run(input vec_t v, input string tag, output int base);
    int sbase, cnt; bit got;
    @(negedge clk);
    dev_address = v.addr; wr_data = v.data; wr_len = v.len; nack_at = v.nack_at; start = 1'b1;
    base = rx_n; sbase = stops;
    @(posedge clk); #1;
    check({tag, " busy_rise"}, busy, 1);
    check({tag, " sda_start"}, {sda_oe, scl_oe}, 2'b10);
    start = 1'b0; dev_address = ~v.addr; wr_data = ~v.data; wr_len = '0;
    wait_done(cnt, got);
    check_result(v, tag, base, sbase, cnt, got);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
  endtask

  vec_t vecs[6];
  vec_t v0, vb;
  int base, gap, cnt, sbase;
  bit got;

  initial begin
    vecs[0] = '{7'h1A, 32'hABCD_1234, 3'd2, -1, 452, 3, 1'b0, 3'd0};
    vecs[1] = '{7'h1A, 32'h0000_0000, 3'd0,  0, 164, 1, 1'b1, 3'd0};
    vecs[2] = '{7'h50, 32'h1122_3344, 3'd3,  2, 452, 3, 1'b1, 3'd2};
    vecs[3] = '{7'h7F, 32'hDEAD_BEEF, 3'd7, -1, 740, 5, 1'b0, 3'd0};
    vecs[4] = '{7'h00, 32'h8000_0001, 3'd4, -1, 740, 5, 1'b0, 3'd0};
    vecs[5] = '{7'h2B, 32'h5AA5_0000, 3'd1,  1, 308, 2, 1'b1, 3'd1};

    #12;
    check("rst sda_oe", sda_oe, 0);
    check("rst scl_oe", scl_oe, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst nack", nack, 0);
    check("rst nack_index", nack_index, 0);
    @(negedge clk); reset_n = 1'b1;

    // first transaction: hand-known bytes
    run(vecs[0], "v0", base);
    check("v0 hand b0", rx[base % 256], 8'h34);
    check("v0 hand b1", rx[(base + 1) % 256], 8'hAB);
    check("v0 hand b2", rx[(base + 2) % 256], 8'hCD);

    for (int i = 1; i < 6; i++) run(vecs[i], $sformatf("v%0d", i), base);

    // back-to-back with start held high
    vb = vecs[3];
    @(negedge clk);
    dev_address = vb.addr; wr_data = vb.data; wr_len = vb.len; nack_at = -1; start = 1'b1;
    base = rx_n; sbase = stops;
    wait_done(cnt, got);
    check_result(vb, "b2b first", base, sbase, cnt, got);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) break;
      gap++;
    end
    check("b2b idle gap", gap, 1);
    base = rx_n - 0; sbase = stops;
    start = 1'b0;
    wait_done(cnt, got);
    check_result(vb, "b2b second", base, sbase, cnt + 1, got);

    // reset mid-byte
    @(negedge clk);
    dev_address = 7'h1A; wr_data = 32'hABCD_1234; wr_len = 3'd2; nack_at = -1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (59) @(negedge clk);
    check("midrst scl_before", scl_oe, 1);
    reset_n = 1'b0; #1;
    check("midrst sda_oe", sda_oe, 0);
    check("midrst scl_oe", scl_oe, 0);
    check("midrst busy", busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run(vecs[0], "after_rst", base);

`ifdef I2C_CLK_STRETCH_EN
    v0 = vecs[0];
    v0.exp_busy = 472;
    stretch_arm = 1;
    run(v0, "stretch", base);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
